alu_op_sequencer: RTL and testbench

Request-side controller for the 32-bit combinational ALU. It accepts operation requests over a valid/ready handshake and encodes each one onto the ALU's A/B/ALUCntl inputs. It captures ALUout and the C/Z/N/V flags into a registered response, and cleans up flag values the ALU leaves undefined. Multi-bit left shifts are built by iterating the ALU's 1-bit shift-left operation, one ALU pass per cycle.

---
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_op_sequencer
// Request-side sequencer for the 32-bit ALU; builds SLL by iterating 1-bit shifts.
// Rev    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [3:0]         req_op_i,
  input  logic [DATA_W-1:0]  req_a_i,
  input  logic [DATA_W-1:0]  req_b_i,
  input  logic [SHAMT_W-1:0] req_shamt_i,
  output logic [DATA_W-1:0]  alu_a_o,
  output logic [DATA_W-1:0]  alu_b_o,
  output logic [3:0]         alu_cntl_o,
  input  logic [DATA_W-1:0]  alu_out_i,
  input  logic               alu_c_i,
  input  logic               alu_z_i,
  input  logic               alu_n_i,
  input  logic               alu_v_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic [3:0]         rsp_flags_o,
  output logic               rsp_err_o
);

  localparam logic [3:0] c_cntl_and  = 4'b0000;
  localparam logic [3:0] c_cntl_or   = 4'b0001;
  localparam logic [3:0] c_cntl_xor  = 4'b0011;
  localparam logic [3:0] c_cntl_nor  = 4'b1100;
  localparam logic [3:0] c_cntl_not  = 4'b0111;
  localparam logic [3:0] c_cntl_addu = 4'b0010;
  localparam logic [3:0] c_cntl_subu = 4'b0110;
  localparam logic [3:0] c_cntl_add  = 4'b1010;
  localparam logic [3:0] c_cntl_sll  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [DATA_W-1:0]    alu_a_q;
  logic [DATA_W-1:0]    alu_b_q;
  logic [3:0]           alu_cntl_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic                 is_sll_q;
  logic                 clean_cv_q;
  logic                 rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic [3:0]           rsp_flags_q;
  logic                 rsp_err_q;

  logic [3:0]           w_cntl;
  logic                 w_legal;
  logic                 w_sll;
  logic                 w_logic;

  always_comb begin
    w_cntl  = c_cntl_and;
    w_legal = 1'b1;
    w_sll   = 1'b0;
    w_logic = 1'b1;
    case (req_op_i)
      4'd0: w_cntl = c_cntl_and;
      4'd1: w_cntl = c_cntl_or;
      4'd2: w_cntl = c_cntl_xor;
      4'd3: w_cntl = c_cntl_nor;
      4'd4: w_cntl = c_cntl_not;
      4'd5: begin w_cntl = c_cntl_addu; w_logic = 1'b0; end
      4'd6: begin w_cntl = c_cntl_subu; w_logic = 1'b0; end
      4'd7: begin w_cntl = c_cntl_add;  w_logic = 1'b0; end
      4'd8: begin w_cntl = c_cntl_sll;  w_sll   = 1'b1; end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cntl_q  <= c_cntl_and;
      cnt_q       <= '0;
      is_sll_q    <= 1'b0;
      clean_cv_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            if (!w_legal) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
              rsp_err_q   <= 1'b1;
              state_q     <= S_RESP;
            end else if (w_sll && (req_shamt_i == '0)) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= req_a_i;
              rsp_flags_q <= {1'b0, (req_a_i == '0), req_a_i[DATA_W-1], 1'b0};
              rsp_err_q   <= 1'b0;
              state_q     <= S_RESP;
            end else begin
              alu_a_q     <= req_a_i;
              alu_b_q     <= w_sll ? '0 : req_b_i;
              alu_cntl_q  <= w_cntl;
              cnt_q       <= req_shamt_i;
              is_sll_q    <= w_sll;
              clean_cv_q  <= w_logic;
              state_q     <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // alu_a_q doubles as the shift working register between passes
          if (!is_sll_q || (cnt_q == SHAMT_W'(1))) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out_i;
            rsp_flags_q <= {alu_c_i & ~clean_cv_q, alu_z_i, alu_n_i, alu_v_i & ~clean_cv_q};
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cntl_q  <= c_cntl_and;
            cnt_q       <= '0;
            state_q     <= S_RESP;
          end else begin
            alu_a_q <= alu_out_i;
            cnt_q   <= cnt_q - SHAMT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE) && !rst;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_cntl_o  = alu_cntl_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_op_sequencer
// Scoreboarded random/directed bench for alu_op_sequencer with an ALU stand-in.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_shamt = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_cntl;
  logic        alu_c, alu_z, alu_n, alu_v;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  logic        junk_c = 1'b0, junk_v = 1'b0;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
    int          lat;
    int          ncyc;
  } exp_t;
  exp_t sb[$];

  alu_op_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_shamt_i(req_shamt),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cntl_o(alu_cntl),
    .alu_out_i(alu_out), .alu_c_i(alu_c), .alu_z_i(alu_z), .alu_n_i(alu_n), .alu_v_i(alu_v),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in; C/V of logic ops are random to expose missing cleanup
  logic [32:0] sum33;
  always_comb begin
    alu_out = '0;
    alu_c   = junk_c;
    alu_v   = junk_v;
    sum33   = '0;
    case (alu_cntl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0011: alu_out = alu_a ^ alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b0111: alu_out = ~alu_a;
      4'b0010, 4'b1010: begin
        sum33   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum33[31:0];
        alu_c   = sum33[32];
        alu_v   = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b0110: begin
        sum33   = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_out = sum33[31:0];
        alu_c   = sum33[32];
        alu_v   = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b1101: begin
        alu_out = {alu_a[30:0], 1'b0};
        alu_c   = alu_a[31];
      end
      default: alu_out = '0;
    endcase
    alu_z = (alu_out == 32'd0);
    alu_n = alu_out[31];
  end

  initial forever begin
    @(posedge clk);
    #3;
    {junk_c, junk_v} = 2'($urandom);
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 0)      rsp_ready = 1'b1;
    else if (rdy_mode == 2) rsp_ready = 1'b0;
    else                    rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh);
    exp_t        e;
    longint      sa, sbv, sr, lim;
    logic [63:0] ua, ub;
    logic [31:0] r;
    logic        c, v;
    lim = 64'sd2147483647;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    e.err = 1'b0; e.lat = 2; e.ncyc = 1; c = 1'b0; v = 1'b0; r = '0; sr = 0;
    case (op)
      4'd0: begin r = a & b; e.ncyc = 0; end
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~(a | b);
      4'd4: r = ~a;
      4'd5, 4'd7: begin
        r = a + b; c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        sr = sa + sbv; v = (sr > lim) || (sr < -lim - 1);
      end
      4'd6: begin
        r = a - b; c = (a >= b);
        sr = sa - sbv; v = (sr > lim) || (sr < -lim - 1);
      end
      4'd8: begin
        r = a << sh; e.ncyc = int'(sh); e.lat = (sh == 0) ? 1 : int'(sh) + 1;
      end
      default: begin e.err = 1'b1; e.lat = 1; e.ncyc = 0; end
    endcase
    e.data  = e.err ? 32'd0 : r;
    e.flags = e.err ? 4'd0 : {c, (r == 32'd0), r[31], v};
    return e;
  endfunction

  // Monitor: latency, ALU activity and hold-stability tracked per response
  int          acc_cyc = 0, first_cyc = 0, hs_cyc = 0, nz_cnt = 0;
  logic        prev_v = 1'b0;
  logic [31:0] h_data;
  logic [3:0]  h_flags;
  logic        h_err;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      nz_cnt = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        nz_cnt  = 0;
      end
      if (alu_cntl != 4'b0000) nz_cnt++;
      if (rsp_valid) begin
        if (!prev_v) begin
          first_cyc = cyc; h_data = rsp_data; h_flags = rsp_flags; h_err = rsp_err;
        end else begin
          chk("hold_data", rsp_data, h_data);
          chk("hold_flags", 32'(rsp_flags), 32'(h_flags));
          chk("hold_err", 32'(rsp_err), 32'(h_err));
        end
        if (rsp_ready) begin
          hs_cyc = cyc + 1;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got data 0x%08h with no request pending, required none", rsp_data);
          end else begin
            m_e = sb.pop_front();
            chk("rsp_data", rsp_data, m_e.data);
            chk("rsp_flags", 32'(rsp_flags), 32'(m_e.flags));
            chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
            chk("latency", 32'(first_cyc - acc_cyc + 1), 32'(m_e.lat));
            chk("alu_busy_cycles", 32'(nz_cnt), 32'(m_e.ncyc));
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic start_req(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
    req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
  endtask

  task automatic wait_accept(input bit push);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1 within 500 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back(ref_model(req_op, req_a, req_b, req_shamt));
    #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 4'($urandom); req_shamt = 5'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    start_req(op, a, b, sh);
    wait_accept(1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  logic [31:0] wa;
  logic [3:0]  rop;
  logic [4:0]  rsh;
  logic [31:0] ra, rb;
  bit          seen;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_alu_cntl", 32'(alu_cntl), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    rdy_mode = 0;
    issue(4'd7, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    issue(4'd6, 32'd5, 32'd5, 5'd0);
    issue(4'd2, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0);
    issue(4'd8, 32'h8000_0001, 32'd0, 5'd4);
    issue(4'd8, 32'h8000_0001, 32'd0, 5'd0);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    issue(4'd3, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    issue(4'd4, 32'hFFFF_FFFF, 32'd0, 5'd0);
    wait_idle();

    // Backpressure: second request must wait for the response handshake
    rdy_mode = 2;
    issue(4'd5, 32'h1234_5678, 32'h1111_1111, 5'd0);
    start_req(4'd6, 32'd100, 32'd1, 5'd0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    rdy_mode = 0;
    wait_accept(1'b1);
    chk("bp_next_accept_edge", 32'(cyc), 32'(hs_cyc + 1));
    wait_idle();

    // Abort a long shift mid-flight
    wa = 32'hA5A5_0F0F;
    start_req(4'd8, wa, 32'd0, 5'd31);
    wait_accept(1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("sll_mid_work", alu_a, wa << 10);
    chk("sll_mid_cntl", 32'(alu_cntl), 32'hD);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_alu_cntl", 32'(alu_cntl), 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    chk("abort_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;

    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rsh = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      issue(rop, ra, rb, rsh);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
